// File: rtl/btb_pkg.sv
// Shared encodings for the BTB port controller: the per-cycle BTB port
// selection and the run/drain control state.
package btb_pkg;

    // What the single BTB port is used for in the current cycle.
    typedef enum logic [1:0] {
        SEL_IDLE   = 2'd0,
        SEL_LOOKUP = 2'd1,
        SEL_UPDATE = 2'd2
    } port_sel_e;

    // Controller state.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/btb_upd_fifo.sv
// Update queue for resolved taken branches. It holds (pc, target) pairs
// until the controller gets a BTB port cycle to write them. The head is
// only meaningful while the queue is non-empty, so a freshly pushed entry
// can never be seen by the controller in the same cycle it arrives.
module btb_upd_fifo #(
    parameter int ADDR_WIDTH  = 24,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic [ADDR_WIDTH-1:0] push_target,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [ADDR_WIDTH-1:0] head_target
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] pc_mem  [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_mem [QUEUE_DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign full        = (count == CNT_W'(QUEUE_DEPTH));
    assign empty       = (count == '0);
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign head_pc     = pc_mem[rd_ptr];
    assign head_target = tgt_mem[rd_ptr];

    // Pointers and occupancy; depth is a power of two so the pointers wrap
    // modulo QUEUE_DEPTH by simply overflowing.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents need no reset since occupancy gates their use.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]  <= push_pc;
            tgt_mem[wr_ptr] <= push_target;
        end
    end

endmodule

// File: rtl/btb_ctrl.sv
// BTB port controller: shares one BTB port between fetch lookups and queued
// branch-target updates, with a drain mode that flushes the update queue.
//
// Optional feature: BTB_CTRL_STARVE_GUARD_EN adds a starvation counter that
// forces a queued update through after STARVE_LIMIT consecutive lookups.
//
//   state | meaning
//   RUN   | normal arbitration, updates accepted, lookups allowed
//   DRAIN | flushing queue; no new updates, no lookups; RUN once empty
module btb_ctrl
    import btb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 24,
    parameter int QUEUE_DEPTH  = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  fetch_gnt,
    output logic                  fetch_rsp_valid,
    output logic                  fetch_rsp_hit,
    output logic [ADDR_WIDTH-1:0] fetch_rsp_target,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    output logic                  upd_ready,
    input  logic                  drain,
    output logic                  drain_done,
    output logic [ADDR_WIDTH-1:0] btb_pc,
    output logic                  btb_branch_taken,
    output logic [ADDR_WIDTH-1:0] btb_target_in,
    input  logic                  btb_hit,
    input  logic [ADDR_WIDTH-1:0] btb_target_out
);

    ctrl_state_e           state;
    ctrl_state_e           state_nxt;
    port_sel_e             sel;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [ADDR_WIDTH-1:0] head_target;
    logic                  starve_trig;
    logic                  force_upd;

    assign upd_ready = !full && (state == ST_RUN);

    btb_upd_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (upd_valid && upd_ready),
        .push_pc    (upd_pc),
        .push_target(upd_target),
        .pop        (sel == SEL_UPDATE),
        .full       (full),
        .empty      (empty),
        .head_pc    (head_pc),
        .head_target(head_target)
    );

`ifdef BTB_CTRL_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] starve_cnt;

    // Count lookups that bypass a waiting update; any update resets it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (sel == SEL_UPDATE) begin
            starve_cnt <= '0;
        end else if (sel == SEL_LOOKUP && !empty) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    assign starve_trig = (starve_cnt == SC_W'(STARVE_LIMIT));
`else
    // Guard disabled: the trigger is tied off (constant false for any limit).
    assign starve_trig = (STARVE_LIMIT < 0);
`endif

    assign force_upd = !empty && (full || state == ST_DRAIN || starve_trig);

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // Port arbitration, next state and drain completion; reset forces IDLE.
    always_comb begin
        sel        = SEL_IDLE;
        state_nxt  = state;
        drain_done = 1'b0;
        if (!reset) begin
            if (force_upd)                        sel = SEL_UPDATE;
            else if (fetch_req && state == ST_RUN) sel = SEL_LOOKUP;
            else if (!empty)                      sel = SEL_UPDATE;

            case (state)
                ST_RUN: begin
                    if (drain) state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (empty) begin
                        state_nxt  = ST_RUN;
                        drain_done = 1'b1;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    assign fetch_gnt        = (sel == SEL_LOOKUP);
    assign btb_branch_taken = (sel == SEL_UPDATE);
    assign btb_pc           = (sel == SEL_UPDATE) ? head_pc : fetch_pc;
    assign btb_target_in    = head_target;

    // Capture the BTB answer of a lookup; hit/target hold between lookups.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_rsp_valid  <= 1'b0;
            fetch_rsp_hit    <= 1'b0;
            fetch_rsp_target <= '0;
        end else if (sel == SEL_LOOKUP) begin
            fetch_rsp_valid  <= 1'b1;
            fetch_rsp_hit    <= btb_hit;
            fetch_rsp_target <= btb_target_out;
        end else begin
            fetch_rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed bench for btb_ctrl with a small behavioural BTB (direct mapped,
// full-PC tag). Inputs change 1 time unit after a rising edge; outputs are
// checked 1 unit later, well away from the edges.
module tb_btb_ctrl;

`ifdef BTB_CTRL_STARVE_GUARD_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [23:0] fetch_pc;
    logic        fetch_gnt;
    logic        fetch_rsp_valid;
    logic        fetch_rsp_hit;
    logic [23:0] fetch_rsp_target;
    logic        upd_valid;
    logic [23:0] upd_pc;
    logic [23:0] upd_target;
    logic        upd_ready;
    logic        drain;
    logic        drain_done;
    logic [23:0] btb_pc;
    logic        btb_branch_taken;
    logic [23:0] btb_target_in;
    logic        btb_hit;
    logic [23:0] btb_target_out;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    btb_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req       (fetch_req),
        .fetch_pc        (fetch_pc),
        .fetch_gnt       (fetch_gnt),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rsp_hit   (fetch_rsp_hit),
        .fetch_rsp_target(fetch_rsp_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_target      (upd_target),
        .upd_ready       (upd_ready),
        .drain           (drain),
        .drain_done      (drain_done),
        .btb_pc          (btb_pc),
        .btb_branch_taken(btb_branch_taken),
        .btb_target_in   (btb_target_in),
        .btb_hit         (btb_hit),
        .btb_target_out  (btb_target_out)
    );

    // Behavioural BTB: 16 slots indexed by pc[9:6], tagged with the full pc.
    logic        m_v   [16];
    logic [23:0] m_tag [16];
    logic [23:0] m_tg  [16];
    logic [3:0]  m_idx;

    always_comb begin
        m_idx          = btb_pc[9:6];
        btb_hit        = m_v[m_idx] && (m_tag[m_idx] == btb_pc);
        btb_target_out = btb_hit ? m_tg[m_idx] : 24'h0;
    end

    // Writes land mid-cycle, when the DUT's port signals are stable.
    always @(negedge clk) begin
        if (btb_branch_taken) begin
            m_v[btb_pc[9:6]]   = 1'b1;
            m_tag[btb_pc[9:6]] = btb_pc;
            m_tg[btb_pc[9:6]]  = btb_target_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_taken;
        reset = 1'b1; fetch_req = 1'b0; fetch_pc = 24'h0;
        upd_valid = 1'b0; upd_pc = 24'h0; upd_target = 24'h0; drain = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 1'b0; m_tag[i] = 24'h0; m_tg[i] = 24'h0;
        end
        m_v[4] = 1'b1; m_tag[4] = 24'h000100; m_tg[4] = 24'h000200;

        step; step;
        #1;
        chk("rst_taken",   32'(btb_branch_taken), 0);
        chk("rst_rsp_v",   32'(fetch_rsp_valid), 0);
        chk("rst_rsp_hit", 32'(fetch_rsp_hit), 0);
        chk("rst_rsp_tgt", 32'(fetch_rsp_target), 0);
        chk("rst_ddone",   32'(drain_done), 0);
        chk("rst_ready",   32'(upd_ready), 1);
        reset = 1'b0;
        step;

        // Lookup hit
        fetch_req = 1'b1; fetch_pc = 24'h000100;
        #1;
        chk("lk_gnt",   32'(fetch_gnt), 1);
        chk("lk_taken", 32'(btb_branch_taken), 0);
        chk("lk_pc",    32'(btb_pc), 32'h100);
        step;
        fetch_req = 1'b0;
        #1;
        chk("lk_rsp_v",   32'(fetch_rsp_valid), 1);
        chk("lk_rsp_hit", 32'(fetch_rsp_hit), 1);
        chk("lk_rsp_tgt", 32'(fetch_rsp_target), 32'h200);
        chk("lk_gnt_off", 32'(fetch_gnt), 0);
        step;
        #1;
        chk("lk_rsp_v_off", 32'(fetch_rsp_valid), 0);
        chk("lk_hold_hit",  32'(fetch_rsp_hit), 1);
        chk("lk_hold_tgt",  32'(fetch_rsp_target), 32'h200);

        // Update on an idle port, one cycle after acceptance
        upd_valid = 1'b1; upd_pc = 24'h000040; upd_target = 24'h000080;
        #1;
        chk("ui_ready",   32'(upd_ready), 1);
        chk("ui_nobyp",   32'(btb_branch_taken), 0);
        step;
        upd_valid = 1'b0;
        #1;
        chk("ui_taken",   32'(btb_branch_taken), 1);
        chk("ui_pc",      32'(btb_pc), 32'h40);
        chk("ui_tgt",     32'(btb_target_in), 32'h80);
        step;
        fetch_req = 1'b1; fetch_pc = 24'h000040;
        #1;
        chk("ui_taken_off", 32'(btb_branch_taken), 0);
        chk("ui_lk_gnt",    32'(fetch_gnt), 1);
        step;
        fetch_req = 1'b0;
        #1;
        chk("ui_lk_v",   32'(fetch_rsp_valid), 1);
        chk("ui_lk_hit", 32'(fetch_rsp_hit), 1);
        chk("ui_lk_tgt", 32'(fetch_rsp_target), 32'h80);
        step;

        // Full queue preempts fetch; lookup of queued pc is not forwarded
        fetch_req = 1'b1; fetch_pc = 24'h000500;
        upd_valid = 1'b1; upd_pc = 24'h000140; upd_target = 24'h0001C0;
        #1;
        chk("fq_gnt_a",   32'(fetch_gnt), 1);
        chk("fq_ready_a", 32'(upd_ready), 1);
        step;
        fetch_pc = 24'h000140; upd_pc = 24'h000180; upd_target = 24'h000240;
        #1;
        chk("fq_gnt_b",   32'(fetch_gnt), 1);
        chk("fq_ready_b", 32'(upd_ready), 1);
        step;
        upd_valid = 1'b0; fetch_pc = 24'h000500;
        #1;
        chk("fq_ready_c", 32'(upd_ready), 0);
        chk("fq_gnt_c",   32'(fetch_gnt), 0);
        chk("fq_taken_c", 32'(btb_branch_taken), 1);
        chk("fq_pc_c",    32'(btb_pc), 32'h140);
        chk("fq_tgt_c",   32'(btb_target_in), 32'h1C0);
        chk("nofwd_v",    32'(fetch_rsp_valid), 1);
        chk("nofwd_hit",  32'(fetch_rsp_hit), 0);
        step;
        #1;
        chk("fq_ready_d", 32'(upd_ready), 1);
        chk("fq_gnt_d",   32'(fetch_gnt), 1);
        chk("fq_taken_d", 32'(btb_branch_taken), 0);
        chk("fq_rsp_v_d", 32'(fetch_rsp_valid), 0);
        step;
        fetch_req = 1'b0;
        #1;
        chk("fq_taken_e", 32'(btb_branch_taken), 1);
        chk("fq_pc_e",    32'(btb_pc), 32'h180);
        chk("fq_rsp_v_e", 32'(fetch_rsp_valid), 1);
        step;

        // Starvation: one queued update under continuous fetch
        fetch_req = 1'b1; fetch_pc = 24'h000500;
        upd_valid = 1'b1; upd_pc = 24'h000600; upd_target = 24'h000640;
        #1;
        chk("sv_gnt0", 32'(fetch_gnt), 1);
        step;
        upd_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            exp_taken = STARVE_ON && (i == 9);
            chk("sv_taken", 32'(btb_branch_taken), 32'(exp_taken));
            chk("sv_gnt",   32'(fetch_gnt), 32'(!exp_taken));
            step;
        end
        fetch_req = 1'b0;
        #1;
        chk("sv_rel_taken", 32'(btb_branch_taken), 32'(!STARVE_ON));
        chk("sv_rel_pc",    32'(btb_pc), STARVE_ON ? 32'h500 : 32'h600);
        step;
        fetch_req = 1'b1; fetch_pc = 24'h000600;
        #1;
        chk("sv_lk_gnt", 32'(fetch_gnt), 1);
        step;
        fetch_req = 1'b0;
        #1;
        chk("sv_lk_hit", 32'(fetch_rsp_hit), 1);
        chk("sv_lk_tgt", 32'(fetch_rsp_target), 32'h640);
        step;

        // Drain with two queued updates
        fetch_req = 1'b1; fetch_pc = 24'h000500;
        upd_valid = 1'b1; upd_pc = 24'h000700; upd_target = 24'h000740;
        #1;
        chk("dr_gnt0", 32'(fetch_gnt), 1);
        step;
        upd_pc = 24'h000780; upd_target = 24'h0007C0; drain = 1'b1;
        #1;
        chk("dr_gnt1",   32'(fetch_gnt), 1);
        chk("dr_ready1", 32'(upd_ready), 1);
        step;
        upd_valid = 1'b0; drain = 1'b0;
        #1;
        chk("dr_gnt2",   32'(fetch_gnt), 0);
        chk("dr_taken2", 32'(btb_branch_taken), 1);
        chk("dr_pc2",    32'(btb_pc), 32'h700);
        chk("dr_ready2", 32'(upd_ready), 0);
        chk("dr_done2",  32'(drain_done), 0);
        step;
        #1;
        chk("dr_gnt3",   32'(fetch_gnt), 0);
        chk("dr_taken3", 32'(btb_branch_taken), 1);
        chk("dr_pc3",    32'(btb_pc), 32'h780);
        chk("dr_done3",  32'(drain_done), 0);
        step;
        #1;
        chk("dr_done4",  32'(drain_done), 1);
        chk("dr_gnt4",   32'(fetch_gnt), 0);
        chk("dr_taken4", 32'(btb_branch_taken), 0);
        chk("dr_ready4", 32'(upd_ready), 0);
        step;
        #1;
        chk("dr_done5",  32'(drain_done), 0);
        chk("dr_gnt5",   32'(fetch_gnt), 1);
        chk("dr_ready5", 32'(upd_ready), 1);
        step;

        // Drain with an empty queue
        fetch_req = 1'b0; drain = 1'b1;
        #1;
        chk("de_done0", 32'(drain_done), 0);
        step;
        drain = 1'b0;
        #1;
        chk("de_done1",  32'(drain_done), 1);
        chk("de_ready1", 32'(upd_ready), 0);
        step;
        #1;
        chk("de_done2",  32'(drain_done), 0);
        chk("de_ready2", 32'(upd_ready), 1);
        step;

        // Reset in the middle of a drain with one queued update
        fetch_req = 1'b1; fetch_pc = 24'h000500; drain = 1'b1;
        upd_valid = 1'b1; upd_pc = 24'h000800; upd_target = 24'h000840;
        #1;
        chk("rd_gnt0",   32'(fetch_gnt), 1);
        chk("rd_ready0", 32'(upd_ready), 1);
        step;
        upd_valid = 1'b0; drain = 1'b0; fetch_req = 1'b0; reset = 1'b1;
        #1;
        chk("rd_taken1", 32'(btb_branch_taken), 0);
        chk("rd_done1",  32'(drain_done), 0);
        step;
        reset = 1'b0;
        #1;
        chk("rd_ready2", 32'(upd_ready), 1);
        chk("rd_taken2", 32'(btb_branch_taken), 0);
        chk("rd_done2",  32'(drain_done), 0);
        chk("rd_rsp_v2", 32'(fetch_rsp_valid), 0);
        step;
        fetch_req = 1'b1; fetch_pc = 24'h000800;
        #1;
        chk("rd_gnt3",   32'(fetch_gnt), 1);
        chk("rd_taken3", 32'(btb_branch_taken), 0);
        step;
        fetch_req = 1'b0;
        #1;
        chk("rd_rsp_v4",   32'(fetch_rsp_valid), 1);
        chk("rd_rsp_hit4", 32'(fetch_rsp_hit), 0);
        step;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
